// File: rtl/mm2s_ram_reader_if.sv
// ============================================================================
// Module      : mm2s_ram_reader_if
// Description : AXI3 read-master and AXI-Stream master bundle for the MM2S
//               RAM reader.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface mm2s_ram_reader_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int AXI_ID_WIDTH   = 6,
  parameter int AXI_DATA_WIDTH = 32
);
  logic [AXI_ID_WIDTH-1:0]   M_AXI_arid;
  logic [ADDR_WIDTH-1:0]     M_AXI_araddr;
  logic [7:0]                M_AXI_arlen;
  logic [2:0]                M_AXI_arsize;
  logic [1:0]                M_AXI_arburst;
  logic [3:0]                M_AXI_arcache;
  logic [2:0]                M_AXI_arprot;
  logic                      M_AXI_arvalid;
  logic                      M_AXI_arready;
  logic [AXI_ID_WIDTH-1:0]   M_AXI_rid;
  logic [AXI_DATA_WIDTH-1:0] M_AXI_rdata;
  logic [1:0]                M_AXI_rresp;
  logic                      M_AXI_rlast;
  logic                      M_AXI_rvalid;
  logic                      M_AXI_rready;
  logic [AXI_DATA_WIDTH-1:0] M_AXIS_tdata;
  logic                      M_AXIS_tlast;
  logic                      M_AXIS_tvalid;
  logic                      M_AXIS_tready;

  modport master (
    output M_AXI_arid, M_AXI_araddr, M_AXI_arlen, M_AXI_arsize, M_AXI_arburst,
    output M_AXI_arcache, M_AXI_arprot, M_AXI_arvalid,
    input  M_AXI_arready,
    input  M_AXI_rid, M_AXI_rdata, M_AXI_rresp, M_AXI_rlast, M_AXI_rvalid,
    output M_AXI_rready,
    output M_AXIS_tdata, M_AXIS_tlast, M_AXIS_tvalid,
    input  M_AXIS_tready
  );

  modport slave (
    input  M_AXI_arid, M_AXI_araddr, M_AXI_arlen, M_AXI_arsize, M_AXI_arburst,
    input  M_AXI_arcache, M_AXI_arprot, M_AXI_arvalid,
    output M_AXI_arready,
    output M_AXI_rid, M_AXI_rdata, M_AXI_rresp, M_AXI_rlast, M_AXI_rvalid,
    input  M_AXI_rready,
    input  M_AXIS_tdata, M_AXIS_tlast, M_AXIS_tvalid,
    output M_AXIS_tready
  );
endinterface

`default_nettype wire

// File: rtl/mm2s_ram_reader.sv
// ============================================================================
// Module      : mm2s_ram_reader
// Description : Fetches a block of words over an AXI3 read master in INCR
//               bursts and plays them out on an AXI-Stream master through a
//               first-word-fall-through FIFO. Optional block looping is
//               enabled with MM2S_RAM_READER_LOOP_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mm2s_ram_reader #(
  parameter int ADDR_WIDTH     = 32,
  parameter int AXI_ID_WIDTH   = 6,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int COUNT_WIDTH    = 16,
  parameter int BURST_LEN      = 16,
  parameter int FIFO_DEPTH     = 32
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [ADDR_WIDTH-1:0]  address,
  input  logic [COUNT_WIDTH-1:0] word_count,
  input  logic                   start,
`ifdef MM2S_RAM_READER_LOOP_EN
  input  logic                   loop,
`endif
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  mm2s_ram_reader_if.master      bus
);

  localparam int c_BYTES = AXI_DATA_WIDTH / 8;
  localparam int c_SIZE  = $clog2(c_BYTES);
  localparam int c_AW    = $clog2(FIFO_DEPTH);
  localparam int c_CW    = c_AW + 1;
  localparam int c_FW    = AXI_DATA_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADDR  = 2'd1,
    S_DATA  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic [ADDR_WIDTH-1:0]  r_base, r_araddr;
  logic [COUNT_WIDTH-1:0] r_word_count, r_remaining;
  logic [7:0]             r_len, r_beat;
  logic                   r_done, r_error;

  logic [c_FW-1:0]        r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [c_CW-1:0]        r_count;

  logic                   w_loop, w_arvalid, w_rready, w_space_ok, w_cross;
  logic                   w_ar_fire, w_r_fire, w_pop, w_final_beat, w_last_word;
  logic                   w_tvalid, w_tlast, w_start_ok, w_start_zero, w_unused;
  logic [7:0]             w_len;
  logic [c_CW-1:0]        w_free;
  logic [12:0]            w_span;
  logic [AXI_DATA_WIDTH-1:0] w_tdata;

`ifdef MM2S_RAM_READER_LOOP_EN
  assign w_loop = loop;
`else
  assign w_loop = 1'b0;
`endif

  assign w_unused     = ^bus.M_AXI_rid;
  assign w_start_ok   = (r_state == S_IDLE) && start && (word_count != '0);
  assign w_start_zero = (r_state == S_IDLE) && start && (word_count == '0);

  assign w_len      = (r_remaining >= COUNT_WIDTH'(BURST_LEN)) ? 8'(BURST_LEN) : 8'(r_remaining);
  assign w_free     = c_CW'(FIFO_DEPTH) - r_count;
  assign w_space_ok = w_free >= c_CW'(w_len);
  // Byte span of the pending burst measured from the start of its 4 KB page
  assign w_span     = {1'b0, r_araddr[11:0]} + (13'(w_len) << c_SIZE);
  assign w_cross    = w_span > 13'd4096;

  assign w_ar_fire    = w_arvalid && bus.M_AXI_arready;
  assign w_r_fire     = w_rready && bus.M_AXI_rvalid;
  assign w_final_beat = (r_beat == r_len - 8'd1);
  assign w_last_word  = (r_remaining == COUNT_WIDTH'(1));

  assign w_tvalid           = (r_count != '0);
  assign {w_tlast, w_tdata} = r_mem[r_rd_ptr];
  assign w_pop              = w_tvalid && bus.M_AXIS_tready;

  always_comb begin
    w_state_nxt = r_state;
    w_arvalid   = 1'b0;
    w_rready    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) w_state_nxt = S_ADDR;
      end
      S_ADDR: begin
        w_arvalid = w_space_ok;
        if (w_arvalid && bus.M_AXI_arready) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_rready = 1'b1;
        if (bus.M_AXI_rvalid && w_final_beat) begin
          w_state_nxt = (!w_last_word || w_loop) ? S_ADDR : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_pop && w_tlast && (r_count == c_CW'(1))) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_base       <= '0;
      r_araddr     <= '0;
      r_word_count <= '0;
      r_remaining  <= '0;
      r_len        <= '0;
      r_beat       <= '0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_done <= (w_pop && w_tlast) || w_start_zero;
      if (w_start_ok) begin
        r_base       <= address & ~ADDR_WIDTH'(c_BYTES - 1);
        r_araddr     <= address & ~ADDR_WIDTH'(c_BYTES - 1);
        r_word_count <= word_count;
        r_remaining  <= word_count;
        r_error      <= 1'b0;
      end
      if (w_ar_fire) begin
        r_len  <= w_len;
        r_beat <= '0;
        if (w_cross) r_error <= 1'b1;
      end
      if (w_r_fire) begin
        r_beat      <= r_beat + 8'd1;
        r_remaining <= r_remaining - COUNT_WIDTH'(1);
        if ((bus.M_AXI_rresp != 2'b00) || (bus.M_AXI_rlast != w_final_beat)) r_error <= 1'b1;
        // Block progress follows the internal beat count, not rlast
        if (w_final_beat) begin
          if (w_last_word && w_loop) begin
            r_remaining <= r_word_count;
            r_araddr    <= r_base;
          end else begin
            r_araddr <= r_araddr + (ADDR_WIDTH'(r_len) << c_SIZE);
          end
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_r_fire) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + c_AW'(1);
      case ({w_r_fire, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Each entry carries its own tlast so looped passes stay delimited
  always_ff @(posedge aclk) begin
    if (w_r_fire) r_mem[r_wr_ptr] <= {w_last_word, bus.M_AXI_rdata};
  end

  assign bus.M_AXI_arid    = '1;
  assign bus.M_AXI_araddr  = r_araddr;
  assign bus.M_AXI_arlen   = w_len - 8'd1;
  assign bus.M_AXI_arsize  = 3'(c_SIZE);
  assign bus.M_AXI_arburst = 2'b01;
  assign bus.M_AXI_arcache = 4'b0011;
  assign bus.M_AXI_arprot  = 3'b000;
  assign bus.M_AXI_arvalid = w_arvalid;
  assign bus.M_AXI_rready  = w_rready;
  assign bus.M_AXIS_tdata  = w_tdata;
  assign bus.M_AXIS_tlast  = w_tvalid && w_tlast;
  assign bus.M_AXIS_tvalid = w_tvalid;

  assign busy  = (r_state != S_IDLE);
  assign done  = r_done;
  assign error = r_error;

endmodule

`default_nettype wire
